// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int          REG_ADDR_W = 3;
    localparam logic [7:0]  NOP_CTRL   = 8'h00;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Flags a decode instruction that sources the register a load
//               in execute has not yet produced.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] rs_addr_decode,
    input  logic [REG_ADDR_W-1:0] rd_addr_decode,
    input  logic                  rs_used_decode,
    input  logic                  rd_used_decode,
    input  logic [REG_ADDR_W-1:0] rd_addr_execute,
    input  logic                  mem_read_execute,
    output logic                  hazard
);

    logic w_rs_match;
    logic w_rd_match;

    assign w_rs_match = rs_used_decode && (rs_addr_decode == rd_addr_execute);
    assign w_rd_match = rd_used_decode && (rd_addr_decode == rd_addr_execute);
    assign hazard     = mem_read_execute && (w_rs_match || w_rd_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush sequencer for the 5-stage pipeline with a
//               saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = pipe_ctrl_pkg::REG_ADDR_W,
    parameter int MEM_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs_addr_decode,
    input  logic [REG_ADDR_W-1:0] rd_addr_decode,
    input  logic                  rs_used_decode,
    input  logic                  rd_used_decode,
    input  logic [REG_ADDR_W-1:0] rd_addr_execute,
    input  logic                  mem_read_execute,
    input  logic                  branch_taken_execute,
    input  logic                  mem_op_mem,
    output logic                  pc_write_en,
    output logic                  fetch_decode_en,
    output logic                  fetch_decode_flush,
    output logic                  decode_exec_en,
    output logic                  decode_exec_bubble,
    output logic                  exec_mem_en,
    output logic                  mem_wb_en,
    output logic [15:0]           stall_cycles
);

    import pipe_ctrl_pkg::*;

    localparam logic       c_mem_multi = (MEM_LATENCY > 1) ? 1'b1 : 1'b0;
    localparam logic [3:0] c_wait_init = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;

    state_t      r_state;
    logic [3:0]  r_wait_cnt;
    logic [15:0] r_stall_cycles;
    logic        w_hazard;
    logic        w_mem_freeze;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .rs_addr_decode   (rs_addr_decode),
        .rd_addr_decode   (rd_addr_decode),
        .rs_used_decode   (rs_used_decode),
        .rd_used_decode   (rd_used_decode),
        .rd_addr_execute  (rd_addr_execute),
        .mem_read_execute (mem_read_execute),
        .hazard           (w_hazard)
    );

    assign w_mem_freeze = mem_op_mem && c_mem_multi;
    assign stall_cycles = r_stall_cycles;

    // Everything stays low while reset is held, independent of the clock.
    always_comb begin
        pc_write_en        = 1'b0;
        fetch_decode_en    = 1'b0;
        fetch_decode_flush = 1'b0;
        decode_exec_en     = 1'b0;
        decode_exec_bubble = 1'b0;
        exec_mem_en        = 1'b0;
        mem_wb_en          = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                RUN: begin
                    if (!w_mem_freeze) begin
                        pc_write_en     = 1'b1;
                        fetch_decode_en = 1'b1;
                        decode_exec_en  = 1'b1;
                        exec_mem_en     = 1'b1;
                        mem_wb_en       = 1'b1;
                        if (branch_taken_execute) begin
                            fetch_decode_flush = 1'b1;
                            decode_exec_bubble = 1'b1;
                        end else if (w_hazard) begin
                            pc_write_en        = 1'b0;
                            fetch_decode_en    = 1'b0;
                            decode_exec_bubble = 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        pc_write_en     = 1'b1;
                        fetch_decode_en = 1'b1;
                        decode_exec_en  = 1'b1;
                        exec_mem_en     = 1'b1;
                        mem_wb_en       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_wait_cnt     <= 4'd0;
            r_stall_cycles <= 16'd0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_mem_freeze) begin
                        r_wait_cnt <= c_wait_init;
                        r_state    <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (r_wait_cnt != 4'd0) begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end else begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
            if (!pc_write_en && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage 16-bit pipeline.
- Detects load-use hazards between the decode and execute stages.
- Resolves taken branches reported from execute.
- Freezes the whole pipeline while a multi-cycle memory access occupies the memory stage.
- Drives the enable, flush and bubble inputs of the PC, fetch/decode, decode/exec, exec/mem and mem/wb pipeline registers, and keeps a saturating stall-cycle counter for performance measurement.

## Interface
- `REG_ADDR_W`, 3: register-address width.
- `MEM_LATENCY`, 3: total cycles a memory op occupies the memory stage. Legal range 1..16.
- `clk` in 1: pipeline clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rs_addr_decode` in `REG_ADDR_W`: Rs of the instruction in decode.
- `rd_addr_decode` in `REG_ADDR_W`: Rd of the instruction in decode.
- `rs_used_decode` in 1: the decode instruction reads Rs.
- `rd_used_decode` in 1: the decode instruction reads Rd as a source.
- `rd_addr_execute` in `REG_ADDR_W`: destination of the instruction in execute.
- `mem_read_execute` in 1: the execute instruction is a load.
- `branch_taken_execute` in 1: the execute instruction is a resolved taken branch.
- `mem_op_mem` in 1: the memory-stage instruction is a load or store.
- `pc_write_en` out 1: PC update enable.
- `fetch_decode_en` out 1: fetch/decode register load enable.
- `fetch_decode_flush` out 1: clear fetch/decode to NOP on this edge.
- `decode_exec_en` out 1: decode/exec register load enable.
- `decode_exec_bubble` out 1: load all-zero control signals into decode/exec instead of the decode outputs.
- `exec_mem_en` out 1: exec/mem register load enable.
- `mem_wb_en` out 1: mem/wb register load enable.
- `stall_cycles` out 16: saturating count of cycles with `pc_write_en`=0.

## Operation
- The FSM has two states.
  - RUN is the reset state.
  - MEM_WAIT holds a down-counter `wait_cnt`, 4 bits wide.
- Outputs are combinational from the state and current inputs.
- Default in RUN: all enables 1, flush and bubble 0.
- RUN priority is highest first; only one action applies per cycle.
  - **Memory freeze** applies if `mem_op_mem`=1 and `MEM_LATENCY`>1.
    - All enables 0; flush and bubble 0; `branch_taken_execute` is ignored.
    - Load `wait_cnt` = `MEM_LATENCY`-2 and go to MEM_WAIT.
  - **Branch flush** applies if `branch_taken_execute`=1.
    - Outputs: `pc_write_en`=1, which loads the target; `fetch_decode_flush`=1; `decode_exec_bubble`=1; remaining enables 1.
    - Any load-use hazard is discarded, because the decode instruction is wrong-path.
  - **Load-use stall** applies if `mem_read_execute`=1 and either of these matches:
    - `rs_used_decode`=1 and `rs_addr_decode`==`rd_addr_execute`;
    - `rd_used_decode`=1 and `rd_addr_decode`==`rd_addr_execute`.
    - Response: `pc_write_en`=0, `fetch_decode_en`=0, `decode_exec_bubble`=1; `exec_mem_en` and `mem_wb_en` stay 1.
    - The state stays RUN. The stall lasts exactly one cycle, because execute then holds the bubble.
- MEM_WAIT:
  - If `wait_cnt`≠0: all enables 0, decrement `wait_cnt`, stay.
  - If `wait_cnt`=0: all enables 1, go to RUN. This is the release cycle; the memory op leaves the memory stage on that edge.
  - The execute stage is frozen, so a taken branch held there remains asserted and is serviced in RUN after the release.
- `stall_cycles` increments on every rising edge where `pc_write_en`=0 and `rst_n`=1. It saturates at 16'hFFFF with no wrap.

## Timing
- Reset (`rst_n`=0), asynchronous:
  - state = RUN, `wait_cnt`=0, `stall_cycles`=0.
  - All enables, flush and bubble are forced to 0 for as long as reset is low.
  - Deassertion takes effect at the first rising edge.
- Reset asserted mid-MEM_WAIT aborts the wait immediately, with no release cycle.
- Detection-to-action latency is 0: each response is applied on the same edge where its condition is true.
- Memory op timing:
  - The pipeline is frozen for `MEM_LATENCY`-1 cycles, then released for 1 cycle, giving `MEM_LATENCY` cycles in the memory stage.
  - `MEM_LATENCY`=1 never enters MEM_WAIT.
- Back-to-back memory ops: a new `mem_op_mem` seen in RUN right after a release starts a fresh freeze.
- A load-use hazard coinciding with a memory freeze is held frozen and re-evaluated in RUN after the release.
- A branch coinciding with a load-use hazard is handled as a branch only: no extra stall cycle.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state enum {RUN, MEM_WAIT};
  - `REG_ADDR_W`;
  - `NOP_CTRL` = 8'h00, the bubble control word used by the decode/exec register.
- One natural sub-module, `load_use_detect`: purely combinational, it compares the decode source addresses against the execute destination and outputs `hazard`.
- The FSM, counter and output logic live in the top module.

## Test plan
- **Load-use:** a load to R3 in execute (`mem_read_execute`=1, `rd_addr_execute`=3) with decode Rs=3, `rs_used_decode`=1.
  - Expect one cycle of `pc_write_en`=0, `fetch_decode_en`=0, `decode_exec_bubble`=1, exec_mem/mem_wb enables 1; `stall_cycles` goes 0→1.
  - Same stimulus with `rs_used_decode`=0 → no stall.
- **Memory freeze:** `MEM_LATENCY`=3, `mem_op_mem`=1 for one cycle in RUN.
  - Expect all enables 0 for 2 cycles, then all 1; `stall_cycles`=2.
- **Branch during freeze:** `branch_taken_execute` held high while in MEM_WAIT.
  - Expect no flush until the release cycle, then `fetch_decode_flush`=1 and `decode_exec_bubble`=1 in the first RUN cycle.
- **Branch + hazard:** branch taken together with a load-use match.
  - Expect `pc_write_en`=1, flush=1, bubble=1, and no stall.
- **Reset mid-wait:** assert `rst_n`=0 during MEM_WAIT.
  - Expect all outputs 0 immediately and `stall_cycles`=0.
  - After release, expect RUN defaults (all enables 1).
- **Saturation:** force `stall_cycles` near 16'hFFFF via long freezes.
  - Expect it to hold at 16'hFFFF.
